// File: rtl/simd_alu_cmd_issuer.sv
// In-order command issuer and result collector for the external SIMD ALU.
// Define SIMD_ALU_CMD_ISSUER_OVF_EN to store and return per-byte overflow flags.
module simd_alu_cmd_issuer #(
  parameter int SIMD_DATA_WIDTH = 256,
  parameter int SIMD_OPC_WIDTH  = 6,
  parameter int TAG_WIDTH       = 4,
  parameter int CMD_DEPTH       = 4,
  parameter int RES_DEPTH       = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [SIMD_DATA_WIDTH-1:0]   cmd_a_i,
  input  logic [SIMD_DATA_WIDTH-1:0]   cmd_b_i,
  input  logic [SIMD_OPC_WIDTH-1:0]    cmd_opcode_i,
  input  logic [TAG_WIDTH-1:0]         cmd_tag_i,
  output logic [SIMD_DATA_WIDTH-1:0]   alu_a_o,
  output logic [SIMD_DATA_WIDTH-1:0]   alu_b_o,
  output logic [SIMD_OPC_WIDTH-1:0]    alu_opcode_o,
  input  logic [SIMD_DATA_WIDTH-1:0]   alu_out_i,
  input  logic [SIMD_DATA_WIDTH/8-1:0] alu_ovf_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [SIMD_DATA_WIDTH-1:0]   res_data_o,
  output logic [SIMD_DATA_WIDTH/8-1:0] res_ovf_o,
  output logic [TAG_WIDTH-1:0]         res_tag_o,
  output logic                         busy_o
);
  localparam int DW  = SIMD_DATA_WIDTH;
  localparam int OW  = SIMD_DATA_WIDTH / 8;
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);
  localparam int CCW = CAW + 1;
  localparam int RCW = RAW + 1;
  localparam int SW  = RAW + 2;

  typedef struct packed {
    logic [DW-1:0]             a;
    logic [DW-1:0]             b;
    logic [SIMD_OPC_WIDTH-1:0] op;
    logic [TAG_WIDTH-1:0]      tag;
  } cmd_t;

  typedef struct packed {
    logic                 v;
    logic [TAG_WIDTH-1:0] tag;
  } stg_t;

  cmd_t                 cmd_mem [CMD_DEPTH];
  logic [DW-1:0]        rdat_mem [RES_DEPTH];
  logic [TAG_WIDTH-1:0] rtag_mem [RES_DEPTH];

  logic [CAW-1:0] cwr_q, cwr_d, crd_q, crd_d;
  logic [CCW-1:0] ccnt_q, ccnt_d;
  logic [RAW-1:0] rwr_q, rwr_d, rrd_q, rrd_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  stg_t           s0_q, s0_d, s1_q;
  logic [DW-1:0]  a_q, a_d, b_q, b_d;
  logic [SIMD_OPC_WIDTH-1:0] op_q, op_d;

  logic          push, issue, cap, pop;
  logic [1:0]    infl;
  logic [SW-1:0] credit;
  cmd_t          head;

  assign head   = cmd_mem[crd_q];
  assign infl   = {1'b0, s0_q.v} + {1'b0, s1_q.v};
  assign credit = SW'(infl) + SW'(rcnt_q);

  assign cmd_ready_o = rst_n_i && (ccnt_q != CCW'(CMD_DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o;
  // Credit counts both in-flight slots so a capture never hits a full FIFO
  assign issue       = (ccnt_q != '0) && (credit < SW'(RES_DEPTH));
  assign cap         = s1_q.v;
  assign res_valid_o = (rcnt_q != '0);
  assign pop         = res_valid_o && res_ready_i;

  always_comb begin
    cwr_d  = cwr_q + CAW'(push);
    crd_d  = crd_q + CAW'(issue);
    ccnt_d = ccnt_q + CCW'(push) - CCW'(issue);
    rwr_d  = rwr_q + RAW'(cap);
    rrd_d  = rrd_q + RAW'(pop);
    rcnt_d = rcnt_q + RCW'(cap) - RCW'(pop);
    s0_d   = '{v: issue, tag: head.tag};
    a_d    = issue ? head.a  : a_q;
    b_d    = issue ? head.b  : b_q;
    op_d   = issue ? head.op : op_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cwr_q  <= '0;
      crd_q  <= '0;
      ccnt_q <= '0;
      rwr_q  <= '0;
      rrd_q  <= '0;
      rcnt_q <= '0;
      s0_q   <= '0;
      s1_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
    end else begin
      cwr_q  <= cwr_d;
      crd_q  <= crd_d;
      ccnt_q <= ccnt_d;
      rwr_q  <= rwr_d;
      rrd_q  <= rrd_d;
      rcnt_q <= rcnt_d;
      s0_q   <= s0_d;
      s1_q   <= s0_q;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      cmd_mem[cwr_q] <= '{a: cmd_a_i, b: cmd_b_i,
                          op: cmd_opcode_i, tag: cmd_tag_i};
    end
    if (cap) begin
      rdat_mem[rwr_q] <= alu_out_i;
      rtag_mem[rwr_q] <= s1_q.tag;
    end
  end

`ifdef SIMD_ALU_CMD_ISSUER_OVF_EN
  logic [OW-1:0] rovf_mem [RES_DEPTH];

  always_ff @(posedge clk_i) begin
    if (cap) begin
      rovf_mem[rwr_q] <= alu_ovf_i;
    end
  end

  assign res_ovf_o = res_valid_o ? rovf_mem[rrd_q] : '0;
`else
  logic unused_ovf;

  assign unused_ovf = ^alu_ovf_i;
  assign res_ovf_o  = '0;
`endif

  assign res_data_o   = res_valid_o ? rdat_mem[rrd_q] : '0;
  assign res_tag_o    = res_valid_o ? rtag_mem[rrd_q] : '0;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_opcode_o = op_q;
  assign busy_o       = (ccnt_q != '0) || (infl != 2'd0) || (rcnt_q != '0);
endmodule
